// File: rtl/reg_shift_sin_pout.sv
// Serial-in, parallel-out receiver: shifts in LSB-first frames framed by
// rx_frame, publishes each complete word on Dout with valid/overrun handshake.
module reg_shift_sin_pout #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             bit_en,
    input  logic             rx_frame,
    input  logic             p_read,
    output logic [WIDTH-1:0] Dout,
    output logic             rx_valid,
    output logic             rx_busy,
    output logic             rx_err,
    output logic             rx_overrun
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_next;
    logic [CW-1:0]    bit_cnt;
    logic             din_s;
    logic             start;
    logic             capture;
    logic             word_done;
    logic             frame_abort;

    // Unknown samples resolve to 0 rather than propagating into the word.
    always_comb begin
        din_s = 1'b0;
        if (din) din_s = 1'b1;
    end

    assign start       = (state == IDLE) && bit_en && rx_frame;
    assign capture     = (state == RECV) && bit_en && rx_frame;
    assign word_done   = capture && (bit_cnt == LAST_BIT);
    assign frame_abort = (state == RECV) && bit_en && !rx_frame;
    assign rx_busy     = (state == RECV);

    always_comb begin
        shift_next = shift;
        for (int i = 0; i < WIDTH; i++) begin
            if (bit_cnt == CW'(i)) shift_next[i] = din_s;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RECV;
            RECV: begin
                if (word_done)        state_next = HOLD;
                else if (frame_abort) state_next = IDLE;
            end
            HOLD: if (bit_en && !rx_frame) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (start) begin
            shift   <= WIDTH'(din_s);
            bit_cnt <= CW'(1);
        end else if (capture) begin
            shift   <= shift_next;
            bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
        end else if (frame_abort) begin
            bit_cnt <= '0;
        end
    end

    // A completing word wins over p_read for rx_valid; p_read wins for overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Dout       <= '0;
            rx_valid   <= 1'b0;
            rx_err     <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_err <= frame_abort;
            if (word_done) Dout <= shift_next;
            if (word_done)   rx_valid <= 1'b1;
            else if (p_read) rx_valid <= 1'b0;
            if (p_read)                      rx_overrun <= 1'b0;
            else if (word_done && rx_valid)  rx_overrun <= 1'b1;
        end
    end

endmodule
